// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: default geometry and
// the controller state encoding.
package dmem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 16;

  // CLEAR zeroes the array one word per cycle; IDLE serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_t;

  // Number of byte-offset bits inside one word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered
// read port. There is no reset; contents are only ever zeroed by the
// controller walking through every word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BL = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BL; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read: data sampled at the edge the read is issued on.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: clears the array after reset, then accepts one
// byte-addressed read or write per cycle and answers each accepted request
// with a single response pulse on the following cycle.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BL = DATA_W / 8;
  localparam int LB = lane_bits(DATA_W);
  localparam int AW = $clog2(DEPTH);
  localparam int HI_SHIFT = LB + AW;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  dmem_state_t       state;
  logic [AW-1:0]     cnt;
  logic              rd_ok;

  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic [ADDR_W-1:0] addr_hi;
  logic [AW-1:0]     word_addr;

  logic              arr_we;
  logic              arr_re;
  logic [BL-1:0]     arr_be;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // Address decode: any set byte-offset bit is a misalignment, and any set
  // bit above the word index means the word lies beyond the array.
  always_comb begin
    addr_hi      = req_addr >> HI_SHIFT;
    misaligned   = |req_addr[LB-1:0];
    out_of_range = |addr_hi;
    req_err      = misaligned | out_of_range;
    word_addr    = req_addr[LB +: AW];
    accept       = req_valid & req_ready;
  end

  // Array port steering: the clear walker owns the port in CLEAR, accepted
  // error-free requests own it in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = '0;
    arr_addr  = word_addr;
    arr_wdata = req_wdata;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = cnt;
      arr_wdata = '0;
    end else if (accept && !rst && !req_err) begin
      arr_we = req_we;
      arr_re = !req_we;
      arr_be = req_be;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Controller FSM, clear counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & req_err;
      rd_ok     <= accept & !req_we & !req_err;
      case (state)
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST_WORD) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: begin
          state     <= CLEAR;
          cnt       <= '0;
          req_ready <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Read data is only exposed for a successful read response.
  assign rsp_rdata = rd_ok ? arr_rdata : '0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_W, default 16, byte-address width; SHALL cover DEPTH*DATA_W/8 bytes.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_be  in  DATA_W/8  byte enables; bit i enables bits [8i+7:8i].
REQ-012 rsp_valid  out  1  response pulse, one cycle per accepted request.
REQ-013 rsp_rdata  out  DATA_W  read data; zero for writes and errored reads.
REQ-014 rsp_err  out  1  accepted request was misaligned or out of range.
REQ-015 init_done  out  1  memory clear complete.

Function
REQ-016 Decode: byte lanes BL = DATA_W/8; word index = req_addr >> log2(BL); word index truncated to log2(DEPTH) bits after range check.
REQ-017 FSM states: CLEAR and IDLE only.
REQ-018 CLEAR: write zero to word cnt, cnt increments each cycle; after word DEPTH-1 is written, next state IDLE.
REQ-019 CLEAR duration: exactly DEPTH cycles.
REQ-020 CLEAR outputs: req_ready=0, init_done=0; req_valid ignored.
REQ-021 IDLE outputs: req_ready=1, init_done=1.
REQ-022 Handshake: a request is accepted in a cycle where req_valid=1 and req_ready=1; at most one per cycle.
REQ-023 There is no response backpressure.
REQ-024 Latency: rsp_valid=1 exactly one cycle after acceptance; otherwise rsp_valid=0.
REQ-025 Error: rsp_err=1 when req_addr low log2(BL) bits are nonzero, or word index >= DEPTH.
REQ-026 Errored write SHALL not modify memory; errored read returns rsp_rdata=0.
REQ-027 Valid write: for each lane with req_be[i]=1, that byte is updated; other lanes retained.
REQ-028 Write response: rsp_rdata=0, rsp_err=0.
REQ-029 Write with req_be all zero SHALL be acknowledged with no memory change.
REQ-030 Valid read: rsp_rdata = word contents at the acceptance edge.
REQ-031 Write to address A accepted in cycle n, read of A accepted in cycle n+1: the read SHALL return the new data.
REQ-032 rsp_rdata and rsp_err SHALL hold 0 whenever rsp_valid=0.

Reset
REQ-033 On rst=1 at a rising edge, on the following cycle: state=CLEAR, cnt=0, req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-034 rst during CLEAR restarts the clear from word 0.
REQ-035 rst in IDLE discards any in-flight response and re-clears the whole array.
REQ-036 The storage array has no reset port; it is zeroed only by CLEAR.

Structure
REQ-037 Shared package dmem_pkg SHALL hold the state enum (CLEAR, IDLE) and the default parameter constants.
REQ-038 Sub-module dmem_array SHALL provide storage: single port, synchronous write with per-byte enable, registered read.
REQ-039 dmem_ctrl SHALL contain the FSM, clear counter, decode/error logic and response registers.

Verification
REQ-040 Reset, then hold req_valid=1 -> req_ready=0 and init_done=0 for 256 cycles; cycle 257 req_ready=1; reads of 0x0000 and 0x01FE return 0x0000.
REQ-041 Write 0xBEEF to 0x0010 with be=2'b11, then read next cycle -> rsp_valid one cycle after each acceptance; read rsp_rdata=0xBEEF.
REQ-042 Write 0x12FF to 0x0010 with be=2'b01 over 0xBEEF -> read returns 0xBEFF; be=2'b00 write -> ack, data unchanged.
REQ-043 Read 0x0011 (misaligned), then write 0x0200 (out of range) -> both rsp_err=1, rsp_rdata=0; word 0x0000 unchanged.
REQ-044 Assert rst at clear cycle 100 -> clear restarts; init_done rises exactly 256 cycles after rst release.
REQ-045 Issue 50 back-to-back random accesses versus a reference model -> every response matches, one rsp_valid per accept.
